// File: rtl/pin_input_filter.sv
// rtl/pin_input_filter.sv - pad input resynchronizer, per-pin glitch filter and edge detector
module pin_input_filter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 4
) (
    input  logic                   clock_160,
    input  logic                   inp_resn,
    input  logic [WIDTH-1:0]       pin_in,
    input  logic [FILTER_BITS-1:0] filt_len,
    input  logic [WIDTH-1:0]       edge_clr,
    output logic [WIDTH-1:0]       pin_filt,
    output logic [WIDTH-1:0]       rise,
    output logic [WIDTH-1:0]       fall,
    output logic [WIDTH-1:0]       edge_flags
);

    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [FILTER_BITS-1:0] cnt      [WIDTH];
    logic [FILTER_BITS-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0]       sync_last;
    logic [WIDTH-1:0]       accept;
    logic [FILTER_BITS-1:0] len_eff;
    logic [FILTER_BITS-1:0] thr;

    assign sync_last = sync_q[SYNC_STAGES-1];
    // A length of 0 behaves like 1: accept on the first disagreeing cycle.
    assign len_eff   = (filt_len == '0) ? FILTER_BITS'(1) : filt_len;
    assign thr       = len_eff - FILTER_BITS'(1);

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            accept[i]   = 1'b0;
            cnt_next[i] = cnt[i];
            if (sync_last[i] == pin_filt[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] >= thr) begin
                // >= rather than == so a shortened length takes effect at once
                accept[i]   = 1'b1;
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + FILTER_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock_160) begin
        if (!inp_resn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            pin_filt   <= '0;
            rise       <= '0;
            fall       <= '0;
            edge_flags <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            pin_filt   <= pin_filt ^ accept;
            rise       <= accept & sync_last;
            fall       <= accept & ~sync_last;
            // set wins over a coincident clear
            edge_flags <= (edge_flags & ~edge_clr) | rise | fall;
        end
    end

endmodule

// File: tb/tb_pin_input_filter.sv
// tb/tb_pin_input_filter.sv - directed self-checking bench for pin_input_filter
module tb_pin_input_filter;

    logic        clock_160;
    logic        inp_resn;
    logic [31:0] pin_in;
    logic [3:0]  filt_len;
    logic [31:0] edge_clr;
    logic [31:0] pin_filt;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] edge_flags;

    int tests_run;
    int tests_failed;

    pin_input_filter #(.WIDTH(32), .SYNC_STAGES(2), .FILTER_BITS(4)) dut (
        .clock_160  (clock_160),
        .inp_resn   (inp_resn),
        .pin_in     (pin_in),
        .filt_len   (filt_len),
        .edge_clr   (edge_clr),
        .pin_filt   (pin_filt),
        .rise       (rise),
        .fall       (fall),
        .edge_flags (edge_flags)
    );

    initial clock_160 = 1'b0;
    always #5 clock_160 = ~clock_160;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle 1 time unit
    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clock_160);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        inp_resn = 1'b0;
        pin_in   = '0;
        edge_clr = '0;
        tick(n);
        inp_resn = 1'b1;
    endtask

    logic [31:0] seen;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        inp_resn     = 1'b0;
        pin_in       = 32'hFFFF_0000;
        filt_len     = 4'd0;
        edge_clr     = '0;

        // reset and power-up
        tick(5);
        check("rst_filt", pin_filt, 32'h0);
        check("rst_flags", edge_flags, 32'h0);
        inp_resn = 1'b1;
        tick(1);
        check("pu_c1_filt", pin_filt, 32'h0);
        check("pu_c1_rise", rise, 32'h0);
        tick(1);
        check("pu_c2_filt", pin_filt, 32'h0);
        tick(1);
        check("pu_c3_filt", pin_filt, 32'hFFFF_0000);
        check("pu_c3_rise", rise, 32'hFFFF_0000);
        check("pu_c3_flags", edge_flags, 32'h0);
        tick(1);
        check("pu_c4_rise", rise, 32'h0);
        check("pu_c4_flags", edge_flags, 32'hFFFF_0000);

        // filter reject: 3-cycle glitch with filt_len 4
        do_reset(2);
        filt_len = 4'd4;
        tick(3);
        pin_in[5] = 1'b1;
        tick(3);
        pin_in[5] = 1'b0;
        seen = '0;
        for (int j = 0; j < 10; j++) begin
            tick(1);
            seen = seen | pin_filt | rise | edge_flags;
        end
        check("reject_any", seen, 32'h0);

        // filter accept: 6 cycles to rise, 6 to fall
        pin_in[5] = 1'b1;
        tick(5);
        check("acc_c5_filt", pin_filt, 32'h0);
        tick(1);
        check("acc_c6_filt", pin_filt, 32'h0000_0020);
        check("acc_c6_rise", rise, 32'h0000_0020);
        tick(1);
        check("acc_c7_rise", rise, 32'h0);
        check("acc_c7_flags", edge_flags, 32'h0000_0020);
        pin_in[5] = 1'b0;
        tick(5);
        check("fall_c5_filt", pin_filt, 32'h0000_0020);
        check("fall_c5_fall", fall, 32'h0);
        tick(1);
        check("fall_c6_filt", pin_filt, 32'h0);
        check("fall_c6_fall", fall, 32'h0000_0020);
        tick(1);
        check("fall_c7_fall", fall, 32'h0);

        // mid-count length change 15 -> 2
        do_reset(2);
        filt_len = 4'd15;
        tick(2);
        pin_in[0] = 1'b1;
        tick(7);
        check("mid_before", pin_filt, 32'h0);
        filt_len = 4'd2;
        tick(1);
        check("mid_after", pin_filt, 32'h0000_0001);
        check("mid_rise", rise, 32'h0000_0001);

        // flag set/clear collision
        do_reset(2);
        filt_len = 4'd1;
        tick(2);
        pin_in[7] = 1'b1;
        tick(3);
        check("col_rise", rise, 32'h0000_0080);
        edge_clr[7] = 1'b1;
        tick(1);
        edge_clr[7] = 1'b0;
        check("col_flag_set", edge_flags, 32'h0000_0080);
        tick(2);
        check("col_flag_hold", edge_flags, 32'h0000_0080);
        edge_clr[7] = 1'b1;
        tick(1);
        edge_clr[7] = 1'b0;
        check("col_flag_clr", edge_flags, 32'h0);
        check("col_filt_kept", pin_filt, 32'h0000_0080);

        // reset mid-filter
        do_reset(2);
        filt_len = 4'd8;
        tick(2);
        pin_in[31] = 1'b1;
        tick(7);
        check("rmf_pre", pin_filt, 32'h0);
        inp_resn = 1'b0;
        tick(1);
        inp_resn = 1'b1;
        check("rmf_rst_filt", pin_filt, 32'h0);
        tick(9);
        check("rmf_c9_filt", pin_filt, 32'h0);
        tick(1);
        check("rmf_c10_filt", pin_filt, 32'h8000_0000);
        check("rmf_c10_rise", rise, 32'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
